music_rom_player: RTL and testbench
===================================

// Module: music_rom_player
// PURPOSE
//  Reader side of the music ROM interface. Walks musicRom (1-cycle synchronous read) from address 0
//  to LAST_ADDR and emits one audio sample every CLKS_PER_SAMPLE clocks to the audio output path.
//  Sits between the game control FSM (play/stop/loop) and the audio codec feeder.
// PARAMETERS
//  ADDR_W          16      ROM address width
//  DATA_W          8       ROM word / sample width (unsigned PCM)
//  LAST_ADDR       16'hFFFF last ROM address of the song (inclusive)
//  CLKS_PER_SAMPLE 6250    clocks per sample period (50 MHz -> 8 kHz); must be >= 3
//  SILENCE         8'h80   sample_out value when not playing (unsigned mid-scale)
// PORTS
//  clock         in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-high
//  play          in   1       start playback from address 0 (level, sampled in IDLE only)
//  stop          in   1       abort playback; priority over play
//  loop          in   1       on song end restart at 0 instead of finishing (sampled at end of last period)
//  rom_address   out  ADDR_W  registered address to musicRom.address
//  rom_q         in   DATA_W  musicRom.q; word for address sampled at previous edge
//  sample_out    out  DATA_W  registered current sample
//  sample_valid  out  1       1-cycle pulse when sample_out updates with a new ROM word
//  playing       out  1       high while not IDLE
//  done          out  1       1-cycle pulse on natural song end (never on stop/reset)
// BEHAVIOUR
//  Reset: state IDLE, rom_address 0, div 0, sample_out SILENCE, sample_valid 0, playing 0, done 0.
//  States: IDLE, FETCH1 (ROM samples address), FETCH2 (rom_q valid), HOLD (wait period end).
//  div: period counter, 0..CLKS_PER_SAMPLE-1, cleared on start, increments every non-IDLE cycle, wraps.
//  IDLE: play=1 & stop=0 -> rom_address<=0, div<=0, FETCH1. Otherwise stay; sample_out=SILENCE.
//  FETCH1 -> FETCH2 unconditionally.
//  FETCH2 -> HOLD; sample_out<=rom_q, sample_valid<=1 (visible in first HOLD cycle).
//  HOLD: stay until div==CLKS_PER_SAMPLE-1, then:
//   rom_address!=LAST_ADDR -> rom_address+1, FETCH1;
//   ==LAST_ADDR & loop=1 -> rom_address<=0, FETCH1 (seamless, period unchanged);
//   ==LAST_ADDR & loop=0 -> IDLE, done<=1, sample_out<=SILENCE.
//  Timing: play sampled at edge ending cycle 0 -> FETCH1 cycle 1, first sample_valid cycle 3,
//   subsequent sample_valid at cycle 3+k*CLKS_PER_SAMPLE exactly.
//  stop=1 in any non-IDLE state -> next cycle IDLE, sample_out SILENCE, sample_valid 0, no done, rom_address 0.
//  play while playing is ignored (no restart). play held high after done restarts next cycle in IDLE.
//  rom_address never exceeds LAST_ADDR; increments without wrap beyond ADDR_W.
//  reset mid-playback overrides everything: next cycle equals reset values.
// TESTING (LAST_ADDR=3, CLKS_PER_SAMPLE=4; ROM model 1-cycle latency, word = addr+8'h10)
//  1 reset 2 cycles -> rom_address 0, sample_out 8'h80, sample_valid/playing/done 0.
//  2 play pulse cycle 0, loop=0 -> sample_valid cycles 3,7,11,15 with 8'h10,11,12,13; done cycle 17; playing 0 from 17, sample_out 8'h80.
//  3 same with loop=1 -> cycle 19 sample_valid with 8'h10, cycle 23 8'h11; done never asserts.
//  4 play cycle 0, stop cycle 9 -> cycle 10 IDLE, playing 0, sample_out 8'h80, no done, no sample_valid after cycle 7.
//  5 play held high throughout -> no restart mid-song; after done at 17, new start, sample_valid at 20 with 8'h10.
//  6 play and stop both high in IDLE -> stays IDLE; reset asserted cycle 6 of playback -> cycle 7 all reset values.

Source files
------------

// File: rtl/music_rom_player_if.sv
// Signal bundle between the music ROM player, its controller, the musicRom and the audio feeder.
// master = player side, slave = the surrounding system (control FSM, ROM, codec feeder).
interface music_rom_player_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              play;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              playing;
  logic              done;

  modport master (
    input  play, stop, loop, rom_q,
    output rom_address, sample_out, sample_valid, playing, done
  );

  modport slave (
    output play, stop, loop, rom_q,
    input  rom_address, sample_out, sample_valid, playing, done
  );
endinterface

// File: rtl/music_rom_player.sv
// Walks a 1-cycle-latency music ROM from address 0 to LAST_ADDR, emitting one
// sample every CLKS_PER_SAMPLE clocks; supports play/stop/loop control.
module music_rom_player #(
  parameter int unsigned          ADDR_W          = 16,
  parameter int unsigned          DATA_W          = 8,
  parameter logic [ADDR_W-1:0]    LAST_ADDR       = 16'hFFFF,
  parameter int unsigned          CLKS_PER_SAMPLE = 6250,
  parameter logic [DATA_W-1:0]    SILENCE         = 8'h80
) (
  input  logic                clock,
  input  logic                reset,
  music_rom_player_if.master  bus
);

  localparam int unsigned DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_SAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH1 = 2'd1,
    FETCH2 = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [ADDR_W-1:0] rom_address_q;
  logic [DATA_W-1:0] sample_out_q;
  logic              sample_valid_q;
  logic              playing_q;
  logic              done_q;

  // div runs freely across FETCH1/FETCH2/HOLD so the sample period is exact
  // regardless of where in the period the ROM fetch happens.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      div_q          <= '0;
      rom_address_q  <= '0;
      sample_out_q   <= SILENCE;
      sample_valid_q <= 1'b0;
      playing_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      if (state_q != IDLE && bus.stop) begin
        state_q       <= IDLE;
        div_q         <= '0;
        rom_address_q <= '0;
        sample_out_q  <= SILENCE;
        playing_q     <= 1'b0;
      end else begin
        if (state_q != IDLE) begin
          div_q <= (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        end
        case (state_q)
          IDLE: begin
            sample_out_q <= SILENCE;
            if (bus.play && !bus.stop) begin
              rom_address_q <= '0;
              div_q         <= '0;
              state_q       <= FETCH1;
              playing_q     <= 1'b1;
            end
          end
          FETCH1: state_q <= FETCH2;
          FETCH2: begin
            sample_out_q   <= bus.rom_q;
            sample_valid_q <= 1'b1;
            state_q        <= HOLD;
          end
          HOLD: begin
            if (div_q == DIV_MAX) begin
              if (rom_address_q != LAST_ADDR) begin
                rom_address_q <= rom_address_q + ADDR_W'(1);
                state_q       <= FETCH1;
              end else if (bus.loop) begin
                rom_address_q <= '0;
                state_q       <= FETCH1;
              end else begin
                state_q      <= IDLE;
                done_q       <= 1'b1;
                sample_out_q <= SILENCE;
                playing_q    <= 1'b0;
              end
            end
          end
          default: begin
            state_q   <= IDLE;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rom_address  = rom_address_q;
  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.playing      = playing_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_music_rom_player.sv
// Directed bench for music_rom_player with LAST_ADDR=3, CLKS_PER_SAMPLE=4 and a
// 1-cycle ROM returning addr+8'h10. Cycle c is the interval after the c-th edge following the play cycle.
module tb_music_rom_player;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  music_rom_player_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  music_rom_player #(
    .ADDR_W(16), .DATA_W(8), .LAST_ADDR(16'd3), .CLKS_PER_SAMPLE(4), .SILENCE(8'h80)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) bus.rom_q <= 8'(bus.rom_address) + 8'h10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.sample_valid) $display("sample cycle=%0d data=%02h", cyc, bus.sample_out);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.play = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cyc = 0;
    check("rst_addr",    32'(bus.rom_address), 32'h0);
    check("rst_sample",  32'(bus.sample_out),  32'h80);
    check("rst_valid",   32'(bus.sample_valid), 32'h0);
    check("rst_playing", 32'(bus.playing),     32'h0);
    check("rst_done",    32'(bus.done),        32'h0);
    reset = 1'b0;
  endtask

  // Halts any ongoing playback and leaves the block idle at the start of a new cycle 0.
  task automatic halt();
    bus.stop = 1'b1; bus.play = 1'b0;
    step();
    check("halt_playing", 32'(bus.playing), 32'h0);
    bus.stop = 1'b0;
    cyc = 0;
  endtask

  initial begin
    bus.play = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0; bus.rom_q = '0;

    // 1: reset values
    do_reset();

    // 2: single song, no loop
    bus.play = 1'b1; bus.loop = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      bus.play = 1'b0;
      check("s2_valid",   32'(bus.sample_valid), 32'(c inside {3, 7, 11, 15}));
      check("s2_done",    32'(bus.done),         32'(c == 17));
      check("s2_playing", 32'(bus.playing),      32'(c <= 16));
      if (c inside {3, 7, 11, 15}) check("s2_data", 32'(bus.sample_out), 32'(8'h10 + 8'((c - 3) / 4)));
      if (c <= 16) check("s2_addr", 32'(bus.rom_address), 32'((c - 1) / 4));
      if (c >= 17) check("s2_silence", 32'(bus.sample_out), 32'h80);
    end

    // 3: loop enabled, wraps seamlessly
    cyc = 0;
    bus.play = 1'b1; bus.loop = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      bus.play = 1'b0;
      check("s3_valid",   32'(bus.sample_valid), 32'(c >= 3 && (c - 3) % 4 == 0));
      check("s3_done",    32'(bus.done),         32'h0);
      check("s3_playing", 32'(bus.playing),      32'h1);
      if (c >= 3 && (c - 3) % 4 == 0)
        check("s3_data", 32'(bus.sample_out), 32'(8'h10 + 8'(((c - 3) / 4) % 4)));
    end
    bus.loop = 1'b0;
    halt();

    // 4: stop mid-song at cycle 9
    bus.play = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      bus.play = 1'b0;
      check("s4_valid",   32'(bus.sample_valid), 32'(c inside {3, 7}));
      check("s4_done",    32'(bus.done),         32'h0);
      check("s4_playing", 32'(bus.playing),      32'(c <= 9));
      if (c >= 10) begin
        check("s4_silence", 32'(bus.sample_out),  32'h80);
        check("s4_addr",    32'(bus.rom_address), 32'h0);
      end
      bus.stop = (c == 9);
    end
    bus.stop = 1'b0;

    // 5: play held high throughout; restart only after done
    cyc = 0;
    bus.play = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      check("s5_valid",   32'(bus.sample_valid), 32'(c inside {3, 7, 11, 15, 20}));
      check("s5_done",    32'(bus.done),         32'(c == 17));
      check("s5_playing", 32'(bus.playing),      32'(c != 17));
      if (c == 15) check("s5_data15", 32'(bus.sample_out), 32'h13);
      if (c == 20) check("s5_data20", 32'(bus.sample_out), 32'h10);
    end
    halt();

    // 6a: play and stop together in IDLE are ignored
    bus.play = 1'b1; bus.stop = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("s6_playing", 32'(bus.playing),      32'h0);
      check("s6_valid",   32'(bus.sample_valid), 32'h0);
      check("s6_sample",  32'(bus.sample_out),   32'h80);
    end

    // 6b: reset mid-playback at cycle 6
    cyc = 0;
    bus.stop = 1'b0; bus.play = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.play = 1'b0;
      if (c <= 6) begin
        check("s6_play_run", 32'(bus.playing), 32'h1);
        if (c >= 3) check("s6_data", 32'(bus.sample_out), 32'h10);
      end else begin
        check("s6_rst_playing", 32'(bus.playing),      32'h0);
        check("s6_rst_sample",  32'(bus.sample_out),   32'h80);
        check("s6_rst_addr",    32'(bus.rom_address),  32'h0);
        check("s6_rst_valid",   32'(bus.sample_valid), 32'h0);
        check("s6_rst_done",    32'(bus.done),         32'h0);
      end
      reset = (c == 6);
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
